lamp_pwm_driver: RTL and testbench
==================================

LAMP_PWM_DRIVER -- requirements
Module: lamp_pwm_driver

Interface
REQ-001 Parameter PWM_BITS, default 4: PWM counter width; period = 2^PWM_BITS dimclk cycles.
REQ-002 Parameter DIM_DUTY, default 4: running-light on-cycles per period; legal range 0..2^PWM_BITS.
REQ-003 Parameter FADE_STEP, default 1: level decrement per period when fading; legal range at least 1.
REQ-004 dimclk  input  1  lamp PWM clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high; clock dimclk.
REQ-006 pat  input  6  lamp pattern from the turn/brake sequencer; each bit is 1 for full on; the source is in the clk domain.
REQ-007 rlight  input  1  running lights enable; the source is in an asynchronous domain.
REQ-008 display  output  6  registered lamp drive; bit i drives lamp i.
REQ-009 pwm_wrap  output  1  registered one-cycle pulse; marks the last cycle of each PWM period.

Function
REQ-010 pat and rlight SHALL each pass through a two-flop dimclk synchronizer, giving pat_s and rlight_s; per-bit skew of one cycle is tolerated.
REQ-011 PWM counter cnt (PWM_BITS wide) SHALL increment every cycle and wrap from 2^PWM_BITS-1 to 0.
REQ-012 pwm_wrap SHALL be 1 exactly in the cycle after cnt equals 2^PWM_BITS-1, and 0 otherwise.
REQ-013 The per-lamp target SHALL be 2^PWM_BITS if pat_s[i]=1; otherwise DIM_DUTY if rlight_s=1; otherwise 0.
REQ-014 Each lamp SHALL hold a level[i] register, PWM_BITS+1 bits wide.
REQ-015 level[i] SHALL update only on the edge where cnt equals 2^PWM_BITS-1, so duty never changes mid-period.
REQ-016 display[i] SHALL register (cnt < level[i]): level 2^PWM_BITS is constantly on, and level 0 is constantly off.
REQ-017 All display bits at equal level SHALL be in phase, with the on-window starting at cnt=0.
REQ-018 A pat or rlight change SHALL take full effect on display within 2^PWM_BITS+4 dimclk cycles.
REQ-019 The pat_s[i] 0-to-1 transition SHALL take priority over any fade: the level jumps to full at the next update.

Reset
REQ-020 While rst=1 at a dimclk edge: synchronizer flops, cnt and level[] SHALL clear to 0, and display and pwm_wrap SHALL clear to 0.
REQ-021 rst asserted mid-period or mid-fade SHALL abort the operation, and display SHALL be 0 from the following cycle.
REQ-022 After release, cnt SHALL restart at 0, and the first pwm_wrap SHALL occur 2^PWM_BITS cycles later.

Configuration
REQ-023 Macro LAMP_FADE_EN selects the fade feature.
REQ-024 Without LAMP_FADE_EN, level[i] SHALL load the target directly at each update.
REQ-025 With LAMP_FADE_EN, a level above its target SHALL decrease by FADE_STEP per update, saturating at the target with no undershoot.
REQ-026 With LAMP_FADE_EN, a level below its target SHALL load the target directly.

Verification
REQ-027 Reset: rst held 3 cycles -> display=0 and pwm_wrap=0; release -> pwm_wrap pulses every 16 cycles (PWM_BITS=4).
REQ-028 Running lights: rlight=1, pat=000000 -> every display bit is high 4 consecutive cycles of each 16, all bits in phase.
REQ-029 Turn pattern: pat=111000, rlight=1 -> within 20 cycles, display[5:3] is constant 1 and display[2:0] runs at 4/16 duty.
REQ-030 Lamps off (no fade): pat 111111 -> 000000 with rlight=0 -> display=000000 within 20 cycles, with no partial period.
REQ-031 Fade (LAMP_FADE_EN, FADE_STEP=1): pat 111111 -> 000000 with rlight=0 -> duty steps 15,14,...,0 one per period; a return to pat=111111 mid-fade gives full on within 20 cycles.
REQ-032 Mid-operation reset: rst for 1 cycle during a fade -> display=0 next cycle, and the level restarts from 0 after release.

Source files
------------

// File: rtl/lamp_pwm_driver.sv
// Lamp PWM driver: synchronizes pattern/running-light inputs and drives 6 lamps
// with period-aligned PWM. Optional level fade selected by macro LAMP_FADE_EN.
module lamp_pwm_driver #(
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned DIM_DUTY  = 4,
  parameter int unsigned FADE_STEP = 1
) (
  input  logic       dimclk,
  input  logic       rst,
  input  logic [5:0] pat,
  input  logic       rlight,
  output logic [5:0] display,
  output logic       pwm_wrap
);

  localparam int unsigned LW   = PWM_BITS + 1;
  localparam int unsigned FULL = 2 ** PWM_BITS;
  localparam logic [LW-1:0] LV_FULL = LW'(FULL);
  localparam logic [LW-1:0] LV_DIM  = LW'(DIM_DUTY);
  localparam logic [LW-1:0] LV_STEP = LW'(FADE_STEP);

  logic [5:0]          pat_m, pat_s;
  logic                rlight_m, rlight_s;
  logic [PWM_BITS-1:0] cnt;
  logic                cnt_last;
  logic [LW-1:0]       level     [6];
  logic [LW-1:0]       level_nxt [6];
  logic [LW-1:0]       tgt       [6];

  assign cnt_last = (cnt == '1);

  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      tgt[i]       = '0;
      level_nxt[i] = level[i];
      if (pat_s[i])
        tgt[i] = LV_FULL;
      else if (rlight_s)
        tgt[i] = LV_DIM;
`ifdef LAMP_FADE_EN
      // Only downward moves fade; any rise (incl. a new pattern bit) loads at once.
      if (level[i] > tgt[i])
        level_nxt[i] = ((level[i] - tgt[i]) > LV_STEP) ? (level[i] - LV_STEP) : tgt[i];
      else
        level_nxt[i] = tgt[i];
`else
      level_nxt[i] = tgt[i];
`endif
    end
  end

  always_ff @(posedge dimclk) begin
    if (rst) begin
      pat_m    <= '0;
      pat_s    <= '0;
      rlight_m <= 1'b0;
      rlight_s <= 1'b0;
      cnt      <= '0;
      pwm_wrap <= 1'b0;
      display  <= '0;
      for (int unsigned i = 0; i < 6; i++)
        level[i] <= '0;
    end else begin
      pat_m    <= pat;
      pat_s    <= pat_m;
      rlight_m <= rlight;
      rlight_s <= rlight_m;
      cnt      <= cnt + 1'b1;
      pwm_wrap <= cnt_last;
      for (int unsigned i = 0; i < 6; i++) begin
        display[i] <= ({1'b0, cnt} < level[i]);
        if (cnt_last)
          level[i] <= level_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_lamp_pwm_driver.sv
// Directed self-checking bench for lamp_pwm_driver (PWM_BITS=4, DIM_DUTY=4).
// Fade checks are compiled when LAMP_FADE_EN is defined.
module tb_lamp_pwm_driver;

  logic       dimclk = 1'b0;
  logic       rst    = 1'b1;
  logic [5:0] pat    = '0;
  logic       rlight = 1'b0;
  logic [5:0] display;
  logic       pwm_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  lamp_pwm_driver #(.PWM_BITS(4), .DIM_DUTY(4), .FADE_STEP(1)) dut (
    .dimclk  (dimclk),
    .rst     (rst),
    .pat     (pat),
    .rlight  (rlight),
    .display (display),
    .pwm_wrap(pwm_wrap)
  );

  always #5 dimclk = ~dimclk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge dimclk);
    @(negedge dimclk);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Display at cycle c shows the compare against cnt=(c-1)%16.
  function automatic int expv(input logic [5:0] full, input int dl, input int c);
    logic [5:0] v;
    for (int b = 0; b < 6; b++)
      v[b] = full[b] | (((c - 1) % 16) < dl);
    return int'(v);
  endfunction

  task automatic check_period(input string tag, input logic [5:0] full, input int dl);
    for (int k = 0; k < 16; k++) begin
      step();
      check(tag, int'(display), expv(full, dl, cyc));
    end
  endtask

`ifdef LAMP_FADE_EN
  task automatic align();
    for (int k = 0; k < 16 && (cyc % 16) != 0; k++) step();
  endtask

  task automatic period_count(output int ones);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      check("fade_inphase", int'(display == 6'h00 || display == 6'h3f), 1);
      ones += int'(display[0]);
    end
  endtask
`endif

  initial begin
    int fz;
    int start;
    int ones;

    // Reset held 3 cycles
    pat = '0; rlight = 1'b0; rst = 1'b1;
    steps(3);
    check("rst_display", int'(display), 0);
    check("rst_wrap", int'(pwm_wrap), 0);
    rst = 1'b0;
    cyc = 0;

    // pwm_wrap pulses on cycles 16, 32 after release
    for (int k = 0; k < 40; k++) begin
      step();
      check("wrap", int'(pwm_wrap), int'((cyc % 16) == 0));
    end

    // Running lights only: 4/16 duty, all in phase
    rlight = 1'b1; pat = 6'b000000;
    steps(20);
    check_period("running", 6'b000000, 4);

    // Turn pattern
    pat = 6'b111000;
    steps(20);
    check_period("turn", 6'b111000, 4);

    // All full on
    pat = 6'b111111; rlight = 1'b0;
    steps(20);
    check_period("full_on", 6'b111111, 0);

`ifndef LAMP_FADE_EN
    // Lamps off: whole periods only, within 20 cycles
    pat = 6'b000000;
    start = cyc;
    fz = -1;
    for (int k = 0; k < 25; k++) begin
      step();
      check("off_whole", int'(display == 6'h00 || display == 6'h3f), 1);
      if (fz < 0 && display == 6'h00) fz = cyc;
    end
    check("off_latency", int'(fz >= 0 && (fz - start) <= 20), 1);
    check("off_phase", (fz - 1) % 16, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("off_hold", int'(display), 0);
    end
`else
    // Fade: duty 15,14,13 per period
    pat = 6'b000000;
    align();
    ones = 16;
    for (int p = 0; p < 3 && ones == 16; p++) period_count(ones);
    check("fade_15", ones, 15);
    period_count(ones);
    check("fade_14", ones, 14);
    period_count(ones);
    check("fade_13", ones, 13);
    // Pattern return mid-fade jumps straight to full
    pat = 6'b111111;
    steps(20);
    check_period("fade_restore", 6'b111111, 0);
    // Reset during a fade; level must restart from 0
    pat = 6'b000000;
    steps(40);
    rst = 1'b1;
    step();
    check("fade_rst_display", int'(display), 0);
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      check("fade_rst_off", int'(display), 0);
    end
    pat = 6'b111111;
    steps(20);
`endif

    // Mid-period reset while lamps are full on
    rst = 1'b1; pat = 6'b000000;
    step();
    check("midrst_display", int'(display), 0);
    check("midrst_wrap", int'(pwm_wrap), 0);
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      check("midrst_wrap_seq", int'(pwm_wrap), int'((cyc % 16) == 0));
      check("midrst_off", int'(display), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
